// File: rtl/p_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// p_hazard_ctrl_if
// Bundles the signals exchanged between the hazard controller and the rest
// of the 5-stage pipeline.
//
//   IR_D/E/M/W      instruction words held in the F/D, D/E, E/M, M/W registers
//   branch_taken_E  branch/jump in E redirects the PC this cycle
//   dmem_ready      data memory completes its access this cycle
//   dmem_req        data memory access request
//   stall_F/D/E/M   hold PC / F/D / D/E / E/M registers
//   flush_D/E/W     zero F/D / D/E / M/W registers
//   fwdA_sel/B_sel  rs1_E/rs2_E source: 00 regfile, 01 M result, 10 W result
//   mem_err         sticky data-memory timeout error
//   stall_cycles    number of cycles with stall_F asserted
//   flush_events    number of branch flushes
//
// The slave modport is the controller, the master modport is the pipeline.
// ---------------------------------------------------------------------------
interface p_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      IR_D;
    logic [31:0]      IR_E;
    logic [31:0]      IR_M;
    logic [31:0]      IR_W;
    logic             branch_taken_E;
    logic             dmem_ready;
    logic             dmem_req;
    logic             stall_F;
    logic             stall_D;
    logic             stall_E;
    logic             stall_M;
    logic             flush_D;
    logic             flush_E;
    logic             flush_W;
    logic [1:0]       fwdA_sel;
    logic [1:0]       fwdB_sel;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport slave (
        input  IR_D, IR_E, IR_M, IR_W, branch_taken_E, dmem_ready,
        output dmem_req, stall_F, stall_D, stall_E, stall_M,
        output flush_D, flush_E, flush_W, fwdA_sel, fwdB_sel,
        output mem_err, stall_cycles, flush_events
    );

    modport master (
        output IR_D, IR_E, IR_M, IR_W, branch_taken_E, dmem_ready,
        input  dmem_req, stall_F, stall_D, stall_E, stall_M,
        input  flush_D, flush_E, flush_W, fwdA_sel, fwdB_sel,
        input  mem_err, stall_cycles, flush_events
    );
endinterface

// File: rtl/p_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// p_hazard_ctrl
// Pipeline sequencing controller for the 5-stage RV32I core (F, D, E, M, W).
// Decodes the D/E/M/W instruction words and produces stall/flush controls,
// E-stage operand forwarding selects, the data-memory request, a timeout
// FSM for data-memory waits and stall/flush performance counters.
//
// Ports:
//   clk   clock, all state on the rising edge
//   rst   synchronous active-high reset
//   bus   p_hazard_ctrl_if.slave (see the interface for signal list)
//
// Parameters:
//   MEM_TIMEOUT  max consecutive dmem wait cycles before ERR (>= 2)
//   CNT_W        width of the performance counters
// ---------------------------------------------------------------------------
module p_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic            clk,
    input  logic            rst,
    p_hazard_ctrl_if.slave  bus
);

    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t          state;
    logic [WC_W-1:0] wait_cnt;

    logic mem_stall;
    logic load_use;
    logic branch_flush;

    // Instruction field helpers; each takes the whole word so the decode
    // rules read the same way for every pipeline stage.
    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[11:7];
    endfunction

    function automatic logic [4:0] f_rs1(input logic [31:0] ir);
        return ir[19:15];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [31:0] ir);
        return ir[24:20];
    endfunction

    function automatic logic is_load(input logic [31:0] ir);
        return ir[6:0] == OP_LOAD;
    endfunction

    function automatic logic is_mem(input logic [31:0] ir);
        return (ir[6:0] == OP_LOAD) || (ir[6:0] == OP_STORE);
    endfunction

    function automatic logic uses_rs1(input logic [31:0] ir);
        return !((ir[6:0] == OP_LUI) || (ir[6:0] == OP_AUIPC) ||
                 (ir[6:0] == OP_JAL));
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ir);
        return (ir[6:0] == OP_OP) || (ir[6:0] == OP_STORE) ||
               (ir[6:0] == OP_BRANCH);
    endfunction

    function automatic logic writes_rd(input logic [31:0] ir);
        logic wr_op;
        wr_op = (ir[6:0] == OP_LOAD)  || (ir[6:0] == OP_OP)    ||
                (ir[6:0] == OP_OPIMM) || (ir[6:0] == OP_LUI)   ||
                (ir[6:0] == OP_AUIPC) || (ir[6:0] == OP_JAL)   ||
                (ir[6:0] == OP_JALR);
        return wr_op && (ir[11:7] != 5'd0);
    endfunction

    // M-stage producers that are loads have no result yet, so only non-load
    // M instructions may forward; M wins over W because it is younger.
    // Since writes_rd excludes rd=x0, a source of x0 can never match.
    function automatic logic [1:0] fwd_sel(input logic [4:0]  rs,
                                           input logic [31:0] ir_m,
                                           input logic [31:0] ir_w);
        if (writes_rd(ir_m) && !is_load(ir_m) && (f_rd(ir_m) == rs))
            return 2'b01;
        else if (writes_rd(ir_w) && (f_rd(ir_w) == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Hazard detection. The data-memory request is dropped while in reset
    // and once the timeout FSM has given up in ERR.
    always_comb begin
        bus.dmem_req = is_mem(bus.IR_M) && ((state == RUN) || (state == MWAIT))
                       && !rst;
        mem_stall    = bus.dmem_req && !bus.dmem_ready;
        load_use     = is_load(bus.IR_E) && writes_rd(bus.IR_E) &&
                       ((uses_rs1(bus.IR_D) && (f_rs1(bus.IR_D) == f_rd(bus.IR_E))) ||
                        (uses_rs2(bus.IR_D) && (f_rs2(bus.IR_D) == f_rd(bus.IR_E))));
    end

    // Stall/flush controls, in strict priority order. A memory wait freezes
    // F..M and bubbles W; a pending branch or load-use in that cycle is
    // simply re-evaluated once M completes, because E is held. A taken
    // branch squashes D and E, which also removes any load-use consumer.
    // A load-use inserts one bubble into E while F and D hold; the next
    // cycle the load sits in M and forwarding/regfile covers the consumer.
    always_comb begin
        bus.stall_F  = 1'b0;
        bus.stall_D  = 1'b0;
        bus.stall_E  = 1'b0;
        bus.stall_M  = 1'b0;
        bus.flush_D  = 1'b0;
        bus.flush_E  = 1'b0;
        bus.flush_W  = 1'b0;
        branch_flush = 1'b0;
        if (rst) begin
            bus.stall_F = 1'b0;
        end else if ((state == ERR) || mem_stall) begin
            bus.stall_F = 1'b1;
            bus.stall_D = 1'b1;
            bus.stall_E = 1'b1;
            bus.stall_M = 1'b1;
            bus.flush_W = 1'b1;
        end else if (bus.branch_taken_E) begin
            bus.flush_D  = 1'b1;
            bus.flush_E  = 1'b1;
            branch_flush = 1'b1;
        end else if (load_use) begin
            bus.stall_F = 1'b1;
            bus.stall_D = 1'b1;
            bus.flush_E = 1'b1;
        end
    end

    // Operand forwarding for E is independent of any stall or flush.
    always_comb begin
        bus.fwdA_sel = fwd_sel(f_rs1(bus.IR_E), bus.IR_M, bus.IR_W);
        bus.fwdB_sel = fwd_sel(f_rs2(bus.IR_E), bus.IR_M, bus.IR_W);
    end

    // Data-memory timeout FSM. The first unready cycle is observed in RUN
    // and already counts as wait cycle 1, so ERR is entered at the end of
    // the MEM_TIMEOUT-th consecutive wait cycle. ERR only leaves on reset.
    // The performance counters live here too and wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            wait_cnt     <= '0;
            bus.mem_err  <= 1'b0;
            bus.stall_cycles <= '0;
            bus.flush_events <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MWAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                MWAIT: begin
                    if (bus.dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WC_W'(MEM_TIMEOUT - 1)) begin
                        state       <= ERR;
                        bus.mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                    end
                end
                ERR: begin
                    state <= ERR;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
            if (bus.stall_F)
                bus.stall_cycles <= bus.stall_cycles + CNT_W'(1);
            if (branch_flush)
                bus.flush_events <= bus.flush_events + CNT_W'(1);
        end
    end

endmodule

// File: doc/p_hazard_ctrl.md
Name: p_hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core (F, D, E, M, W).
- Decodes the instruction words held in the D, E, M and W pipeline registers.
- Drives stall (hold) and flush (zero/bubble) controls for the PC and every inter-stage register, plus operand-forwarding selects for E.
- Handles data-memory handshake waits with a timeout FSM, and keeps stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive dmem wait cycles before entering ERR (>=2)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
IR_D  in  32  instruction in F/D register
IR_E  in  32  instruction in D/E register
IR_M  in  32  instruction in E/M register
IR_W  in  32  instruction in M/W register
branch_taken_E  in  1  branch/jump in E redirects PC this cycle
dmem_ready  in  1  data memory completes access this cycle
dmem_req  out  1  data memory access request
stall_F  out  1  hold PC
stall_D  out  1  hold F/D register
stall_E  out  1  hold D/E register
stall_M  out  1  hold E/M register
flush_D  out  1  zero F/D register
flush_E  out  1  zero D/E register (bubble)
flush_W  out  1  zero M/W register (bubble)
fwdA_sel  out  2  rs1_E source: 00 regfile, 01 M result, 10 W result
fwdB_sel  out  2  rs2_E source, same encoding
mem_err  out  1  sticky timeout error
stall_cycles  out  CNT_W  count of cycles with stall_F=1
flush_events  out  CNT_W  count of branch flushes

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high on rst.
- Decode fields: opcode[6:0], rd[11:7], rs1[19:15], rs2[24:20].
  - load=0000011, store=0100011, branch=1100011, jal=1101111, jalr=1100111, lui=0110111, auipc=0010111, op=0110011, opimm=0010011.
- Operand use:
  - uses_rs1 = opcode not in {lui, auipc, jal}.
  - uses_rs2 = opcode in {op, store, branch}.
  - writes_rd = opcode in {load, op, opimm, lui, auipc, jal, jalr} and rd!=0.
- dmem_req = (IR_M is load or store) and state==RUN/MWAIT and !rst.
- mem_stall = dmem_req and !dmem_ready.
- load_use = IR_E is load, writes_rd(E), and ((uses_rs1(D) and rs1_D==rd_E) or (uses_rs2(D) and rs2_D==rd_E)).
- FSM states:
  - RUN:
    - mem_stall -> MWAIT, wait_cnt<=1.
    - otherwise stay in RUN.
  - MWAIT:
    - dmem_ready -> RUN, wait_cnt<=0.
    - else if wait_cnt==MEM_TIMEOUT-1 -> ERR, mem_err<=1.
    - else wait_cnt<=wait_cnt+1.
  - ERR: absorbing until rst. dmem_req=0.
- Control outputs are combinational, evaluated in priority order:
  1. rst=1: all stall/flush 0.
  2. state==ERR: stall_F/D/E/M=1, flush_W=1.
  3. mem_stall: stall_F/D/E/M=1, flush_W=1. Branch and load-use are ignored; they are re-evaluated once M completes, because E is held.
  4. branch_taken_E: flush_D=1, flush_E=1, stall_F=0 (PC takes the target). Load-use is ignored because D is squashed.
  5. load_use: stall_F=1, stall_D=1, flush_E=1 for exactly one cycle. Next cycle the load is in M and no load-use remains.
  6. Otherwise all 0.
- Forwarding (combinational, independent of stalls):
  - fwdA_sel=01 if writes_rd(M), IR_M not a load, and rd_M==rs1_E.
  - else 10 if writes_rd(W) and rd_W==rs1_E.
  - else 00.
  - fwdB_sel is the same rule using rs2_E.
  - M has priority over W.
  - rs=x0 never forwards.
- Counters:
  - stall_cycles increments on every cycle with stall_F=1.
  - flush_events increments on every cycle where priority 4 fires.
  - Both wrap modulo 2^CNT_W.
- Reset: state<=RUN, wait_cnt<=0, mem_err<=0, both counters<=0. Reset applied mid-MWAIT or in ERR returns to RUN the next cycle.

Test Plan:
- Load-use: IR_E=lw x5,0(x1) (0x0000A283), IR_D=add x6,x5,x2 (0x00228333) -> one cycle stall_F=stall_D=flush_E=1; next cycle all 0; stall_cycles=1.
- Branch flush: branch_taken_E=1 while the load-use condition above also holds -> flush_D=flush_E=1, stall_F=0; flush_events increments by 1; stall_cycles unchanged.
- Memory wait: IR_M=sw, dmem_ready low 3 cycles then high -> dmem_req=1 for 4 cycles; stall_F/D/E/M=1 and flush_W=1 for 3 cycles; state returns to RUN; branch_taken_E asserted during the wait is not acted on.
- Timeout: IR_M=lw, dmem_ready held low (MEM_TIMEOUT=16) -> mem_err=1 after cycle 16 of waiting; afterwards dmem_req=0 and all stalls stay 1; rst pulse clears mem_err and the counters.
- Forwarding:
  - IR_M=add x7,... and IR_W=addi x7,... with IR_E using rs1=x7, rs2=x0 -> fwdA_sel=01, fwdB_sel=00.
  - Change IR_M to a load of x7 -> fwdA_sel=10.
- Reset mid-MWAIT: assert rst in wait cycle 2 -> all outputs 0 that cycle; after rst falls, state is RUN with wait_cnt=0.
